cpu_bus_master: RTL
===================

Name: cpu_bus_master

Overview:
- Parametrised external-bus sequencer between the 6502/65832 core and the system bus.
- Converts one core access request of 1, 2 or 4 bytes into a sequence of byte-wide bus beats with a ready handshake.
- Little-endian beat order; read data is assembled on the return path.
- Adds features the core's single-beat bus path lacks: 6502 page-wrap addressing, bus timeout with error report, and back-to-back requests.

Parameters:
- ADDR_W, 32, width of core and bus address.
- DATA_W, 32, core-side data width; must be a multiple of BUS_W.
- BUS_W, 8, external bus data width per beat.
- TIMEOUT, 255, maximum cycles to wait for ready per beat; 0 disables the timeout.
- WRAP_BITS, 8, low address bits that wrap when i_wrap=1.

Ports:
- i_cpu_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_req  in  1  access request; sampled only when the block can accept
- i_we  in  1  1=write, 0=read
- i_size  in  2  0=1 beat, 1=2 beats, 2=4 beats, 3=illegal
- i_wrap  in  1  wrap beat addresses within a 2^WRAP_BITS page
- i_addr  in  ADDR_W  first-byte address
- i_wdata  in  DATA_W  write data, little-endian
- o_busy  out  1  access in progress
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  valid with o_done: timeout or illegal size
- o_rdata  out  DATA_W  assembled read data, zero-extended
- o_bus_clk  out  1  bus strobe
- o_bus_we  out  1  bus write enable
- o_bus_addr  out  ADDR_W  bus address
- o_bus_data  out  BUS_W  bus write data
- i_bus_data  in  BUS_W  bus read data
- i_bus_data_ready  in  1  bus ready

Behaviour:
- Reset values: all outputs 0; state IDLE; beat and timeout counters 0. A reset mid-operation aborts immediately, drops o_bus_clk asynchronously, and produces no o_done.
- States: IDLE, SETUP, STROBE, DONE.
- Acceptance: a request is accepted at an edge where i_req=1 and the state is IDLE or DONE. Accepting latches we, size, wrap, addr and wdata, clears o_rdata and the beat counter k, and moves to SETUP.
- Illegal size: if i_size=3, or the beat count exceeds DATA_W/BUS_W, go directly to DONE with o_err=1 and perform no bus activity.
- SETUP: drive o_bus_addr=beat address(k) and o_bus_we; on a write, drive o_bus_data=wdata[k*BUS_W +: BUS_W]. o_bus_clk=0. Next state is STROBE.
- STROBE: o_bus_clk=1; address, data and we are held stable. At each edge, i_bus_data_ready is sampled.
  - Ready=1: on a read, capture i_bus_data into o_rdata[k*BUS_W +: BUS_W]. Then k+1 < beats → SETUP with k+1; otherwise → DONE with o_err=0.
  - Ready=0: increment the timeout counter. Reaching TIMEOUT (when nonzero) → DONE with o_err=1; already-captured bytes are kept in o_rdata.
- DONE: o_done=1 for one cycle; o_busy=0; o_bus_clk=0. Next state is SETUP on a new accepted request, otherwise IDLE.
- o_busy=1 in SETUP and STROBE.
- Beat address:
  - i_wrap=0: i_addr+k, modulo 2^ADDR_W.
  - i_wrap=1: upper bits of i_addr kept; low WRAP_BITS = (i_addr[WRAP_BITS-1:0]+k) mod 2^WRAP_BITS.
- Latency: with zero-wait ready, an N-beat access asserts o_done 2N+1 cycles after the accept edge; each wait cycle adds 1.
- o_rdata is stable from the DONE cycle until the next accept edge. On a write, o_rdata=0.
- i_req in SETUP or STROBE is ignored, not queued.
- The timeout counter resets at every SETUP.

Decomposition:
- Shared package cpu_bus_pkg: state encoding (IDLE/SETUP/STROBE/DONE), size codes (SZ_8, SZ_16, SZ_32, SZ_BAD), and a beats-from-size function.
- One sub-module, cpu_bus_addr_gen: combinational beat-address generator with inputs base, k and wrap, parametrised by ADDR_W and WRAP_BITS.
- The top level holds the FSM, counters and the data shift/assembly logic.

Test Plan:
- 1-byte read at 0x00001234, ready tied high, bus returns 0xA5 → o_bus_addr=0x1234, o_done 3 cycles after accept, o_rdata=0x000000A5, o_err=0.
- 4-byte write of 0xDEADBEEF at 0x0200 → beats at 0x0200..0x0203 carrying EF, BE, AD, DE; o_bus_we=1 each beat; o_done after 9 cycles.
- 2-byte read, i_wrap=1, addr 0x000012FF, bytes 0x34 then 0x12 → addresses 0x12FF then 0x1200; o_rdata=0x00001234. Repeat with i_wrap=0 → second address 0x1300.
- TIMEOUT=4, ready held low on beat 0 of a 4-byte read → o_done with o_err=1 after 4 wait cycles; o_bus_clk returns to 0; next request accepted normally.
- i_size=3 → o_done and o_err=1 one cycle after accept, o_bus_clk never asserted. Separately, a new request presented during DONE → back-to-back accept with no IDLE cycle.
- i_rst asserted while in STROBE of beat 1 → o_bus_clk, o_busy and o_done drop to 0 immediately; the first post-reset request completes correctly.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU external-bus sequencer: FSM states,
// access size codes and the size-to-beat-count helper.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_8   = 2'd0,
        SZ_16  = 2'd1,
        SZ_32  = 2'd2,
        SZ_BAD = 2'd3
    } size_e;

    // Number of byte beats for a size code; 0 marks an illegal code.
    function automatic logic [2:0] beats_from_size(input logic [1:0] sz);
        case (size_e'(sz))
            SZ_8:    return 3'd1;
            SZ_16:   return 3'd2;
            SZ_32:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_bus_addr_gen.sv
// Beat address generator: base + k, either linear over the full address
// or wrapping inside a 2^WRAP_BITS page (6502 page-wrap behaviour).
module cpu_bus_addr_gen #(
    parameter int ADDR_W    = 32,
    parameter int WRAP_BITS = 8
) (
    input  logic [ADDR_W-1:0] base_i,
    input  logic [2:0]        k_i,
    input  logic              wrap_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0]    lin_addr;
    logic [WRAP_BITS-1:0] low_addr;

    assign lin_addr = base_i + ADDR_W'(k_i);
    assign low_addr = base_i[WRAP_BITS-1:0] + WRAP_BITS'(k_i);
    assign addr_o   = wrap_i ? {base_i[ADDR_W-1:WRAP_BITS], low_addr} : lin_addr;

endmodule

// File: rtl/cpu_bus_master.sv
// External-bus sequencer: splits one 1/2/4-byte core access into
// little-endian byte beats (SETUP then STROBE per beat), waits on the bus
// ready with an optional timeout, and assembles read data.
module cpu_bus_master
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BUS_W     = 8,
    parameter int TIMEOUT   = 255,
    parameter int WRAP_BITS = 8
) (
    input  logic              i_cpu_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [1:0]        i_size,
    input  logic              i_wrap,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_bus_clk,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [BUS_W-1:0]  o_bus_data,
    input  logic [BUS_W-1:0]  i_bus_data,
    input  logic              i_bus_data_ready
);

    localparam int NB = DATA_W / BUS_W;
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_e            state_q;
    logic              we_q, wrap_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;     // remaining write bytes, shifted down per beat
    logic [2:0]        beats_q, k_q;
    logic [TW-1:0]     tcnt_q;
    logic              busy_q, done_q, err_q, bus_clk_q, bus_we_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [BUS_W-1:0]  bus_data_q;

    logic              can_accept;
    logic [2:0]        beats_d;
    logic              size_bad;
    logic [ADDR_W-1:0] base_d;
    logic [2:0]        k_d;
    logic              wrap_d;
    logic [ADDR_W-1:0] beat_addr;
    logic              tmo_hit;

    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign beats_d    = beats_from_size(i_size);
    assign size_bad   = (beats_d == 3'd0) || (int'(beats_d) > NB);
    assign tmo_hit    = (TIMEOUT != 0) && (tcnt_q == TW'(TIMEOUT - 1));

    // Address of the next SETUP beat: beat 0 of a new request, or k+1 of the current one.
    always_comb begin
        base_d = addr_q;
        k_d    = k_q + 3'd1;
        wrap_d = wrap_q;
        if (can_accept) begin
            base_d = i_addr;
            k_d    = 3'd0;
            wrap_d = i_wrap;
        end
    end

    cpu_bus_addr_gen #(
        .ADDR_W   (ADDR_W),
        .WRAP_BITS(WRAP_BITS)
    ) u_addr_gen (
        .base_i(base_d),
        .k_i   (k_d),
        .wrap_i(wrap_d),
        .addr_o(beat_addr)
    );

    // Sequencer FSM with all bus/core outputs registered.
    always_ff @(posedge i_cpu_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            wrap_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            beats_q    <= '0;
            k_q        <= '0;
            tcnt_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            bus_clk_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            rdata_q    <= '0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    busy_q    <= 1'b0;
                    bus_clk_q <= 1'b0;
                    err_q     <= 1'b0;
                    state_q   <= ST_IDLE;
                    if (i_req) begin
                        we_q    <= i_we;
                        wrap_q  <= i_wrap;
                        addr_q  <= i_addr;
                        beats_q <= beats_d;
                        k_q     <= 3'd0;
                        tcnt_q  <= '0;
                        rdata_q <= '0;
                        if (size_bad) begin
                            // Illegal size completes immediately with no bus cycle.
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q    <= ST_SETUP;
                            busy_q     <= 1'b1;
                            bus_we_q   <= i_we;
                            bus_addr_q <= beat_addr;
                            bus_data_q <= i_we ? i_wdata[BUS_W-1:0] : '0;
                            wdata_q    <= i_wdata >> BUS_W;
                        end
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_STROBE;
                    bus_clk_q <= 1'b1;
                    tcnt_q    <= '0;
                end
                ST_STROBE: begin
                    if (i_bus_data_ready) begin
                        if (!we_q)
                            rdata_q[int'(k_q)*BUS_W +: BUS_W] <= i_bus_data;
                        bus_clk_q <= 1'b0;
                        if ((k_q + 3'd1) < beats_q) begin
                            state_q    <= ST_SETUP;
                            k_q        <= k_q + 3'd1;
                            bus_addr_q <= beat_addr;
                            bus_data_q <= we_q ? wdata_q[BUS_W-1:0] : '0;
                            wdata_q    <= wdata_q >> BUS_W;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end else if (tmo_hit) begin
                        // Give up on this beat; bytes captured so far stay in rdata.
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                        busy_q    <= 1'b0;
                        bus_clk_q <= 1'b0;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_rdata    = rdata_q;
    assign o_bus_clk  = bus_clk_q;
    assign o_bus_we   = bus_we_q;
    assign o_bus_addr = bus_addr_q;
    assign o_bus_data = bus_data_q;

endmodule
